// File: rtl/bp_local_pred_if.sv
// Lookup (F stage), update (M stage) and status signals of the local-history branch predictor.
// The master modport is the pipeline side; the slave modport is the predictor.
interface bp_local_pred_if #(
    parameter int unsigned BHT_IDX_W = 3,
    parameter int unsigned TAG_W     = 3
);
    logic [BHT_IDX_W-1:0] f_bht_idx;
    logic [TAG_W-1:0]     f_tag;
    logic                 pred_taken;
    logic                 pred_strong;
    logic                 ready;
    logic                 m_upd_valid;
    logic [BHT_IDX_W-1:0] m_bht_idx;
    logic [TAG_W-1:0]     m_tag;
    logic                 m_taken;
    logic                 m_mispredict;
    logic [31:0]          stat_upd;
    logic [31:0]          stat_miss;

    modport master (
        output f_bht_idx, f_tag, m_upd_valid, m_bht_idx, m_tag, m_taken, m_mispredict,
        input  pred_taken, pred_strong, ready, stat_upd, stat_miss
    );

    modport slave (
        input  f_bht_idx, f_tag, m_upd_valid, m_bht_idx, m_tag, m_taken, m_mispredict,
        output pred_taken, pred_strong, ready, stat_upd, stat_miss
    );
endinterface

// File: rtl/bp_local_pred.sv
// Local-history branch predictor: per-PC history (BHT) plus PC tag indexes a PHT of saturating
// counters. Combinational lookup, single-port update, init sweep after reset, update statistics.
module bp_local_pred #(
    parameter int unsigned BHT_IDX_W = 3,
    parameter int unsigned HIST_W    = 4,
    parameter int unsigned TAG_W     = 3,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned INIT_CNT  = 1
) (
    input logic            clk,
    input logic            rst,
    bp_local_pred_if.slave bus
);
    localparam int unsigned PHT_IDX_W = TAG_W + HIST_W;
    localparam int unsigned PHT_DEPTH = 2 ** PHT_IDX_W;
    localparam int unsigned BHT_DEPTH = 2 ** BHT_IDX_W;
    localparam int unsigned SWEEP_W   = (PHT_IDX_W > BHT_IDX_W) ? PHT_IDX_W : BHT_IDX_W;
    localparam logic [CNT_W-1:0] CMAX     = '1;
    localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(INIT_CNT);

    typedef enum logic {StInit, StReady} state_e;

    state_e             state_q, state_d;
    logic [SWEEP_W-1:0] ptr_q, ptr_d;
    logic [31:0]        stat_upd_q, stat_upd_d;
    logic [31:0]        stat_miss_q, stat_miss_d;

    logic [HIST_W-1:0] bht_q [BHT_DEPTH];
    logic [CNT_W-1:0]  pht_q [PHT_DEPTH];

    logic                 sweep_pht_en, sweep_bht_en, upd_en;
    logic [HIST_W-1:0]    f_hist, m_hist, m_hist_next;
    logic [PHT_IDX_W-1:0] f_pidx, m_pidx;
    logic [CNT_W-1:0]     f_cnt, m_cnt, m_cnt_next;

    // Sweep pointer spans the larger table; the smaller one is only written while in range.
    assign sweep_pht_en = {1'b0, ptr_q} < (SWEEP_W + 1)'(PHT_DEPTH);
    assign sweep_bht_en = {1'b0, ptr_q} < (SWEEP_W + 1)'(BHT_DEPTH);
    assign upd_en       = (state_q == StReady) && bus.m_upd_valid;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        stat_upd_d  = stat_upd_q + 32'(upd_en);
        stat_miss_d = stat_miss_q + 32'(upd_en && bus.m_mispredict);
        unique case (state_q)
            StInit: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == '1) begin
                    state_d = StReady;
                end
            end
            StReady: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StInit;
            ptr_q       <= '0;
            stat_upd_q  <= '0;
            stat_miss_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            stat_upd_q  <= stat_upd_d;
            stat_miss_q <= stat_miss_d;
        end
    end

    // Lookup path reads the tables as they stand; updates land at the edge, so no bypass.
    always_comb begin
        f_hist = bht_q[bus.f_bht_idx];
        f_pidx = {bus.f_tag, f_hist};
        f_cnt  = pht_q[f_pidx];
    end

    assign bus.ready       = (state_q == StReady);
    assign bus.pred_taken  = bus.ready && f_cnt[CNT_W-1];
    assign bus.pred_strong = bus.ready && ((f_cnt == '0) || (f_cnt == CMAX));
    assign bus.stat_upd    = stat_upd_q;
    assign bus.stat_miss   = stat_miss_q;

    always_comb begin
        m_hist      = bht_q[bus.m_bht_idx];
        m_pidx      = {bus.m_tag, m_hist};
        m_cnt       = pht_q[m_pidx];
        m_cnt_next  = m_cnt;
        if (bus.m_taken) begin
            if (m_cnt != CMAX) m_cnt_next = m_cnt + 1'b1;
        end else begin
            if (m_cnt != '0) m_cnt_next = m_cnt - 1'b1;
        end
        // Shift form also covers single-bit history, where the result is just m_taken.
        m_hist_next = (m_hist << 1) | HIST_W'(bus.m_taken);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == StInit) begin
                if (sweep_pht_en) pht_q[ptr_q[PHT_IDX_W-1:0]] <= INIT_VAL;
                if (sweep_bht_en) bht_q[ptr_q[BHT_IDX_W-1:0]] <= '0;
            end else if (upd_en) begin
                pht_q[m_pidx]        <= m_cnt_next;
                bht_q[bus.m_bht_idx] <= m_hist_next;
            end
        end
    end
endmodule
